drc_sram_bank: RTL and testbench

- Parametrised N_WAY set-associative line store backing the DRC cache read and write ports.
- Successor to the fixed 1-cycle SRAM port:
  - configurable read latency;
  - parametrised field widths;
  - per-line invalidate;
  - hardware invalidate-all sweep with ready gating;
  - defined same-cycle read/write collision behaviour.
- Valid bits are flops; all other fields are array storage.

---
 rtl/drc_sram_bank_if.sv | 56 +++++
 rtl/drc_sram_bank.sv | 191 +++++++++++++++++++
 tb/tb_drc_sram_bank.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drc_sram_bank_if.sv
// rtl/drc_sram_bank_if.sv - request/response bundle for the DRC set-associative line store
// master drives requests and payload; slave is the line store.
interface drc_sram_bank_if #(
  parameter int N_ENTRY    = 64,
  parameter int N_WAY      = 4,
  parameter int ADDR_SIZE  = 24,
  parameter int SYN_WIDTH  = 32,
  parameter int CNT_WIDTH  = 15,
  parameter int DATA_WIDTH = 272
);
  localparam int N_SET     = N_ENTRY / N_WAY;
  localparam int IDX_SIZE  = $clog2(N_SET);
  localparam int TAG_SIZE  = ADDR_SIZE - IDX_SIZE;
  localparam int WAY_WIDTH = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  logic                            req_ready;
  logic                            rden;
  logic [IDX_SIZE-1:0]             raddr;
  logic                            rdata_vld;
  logic [N_WAY-1:0]                rdata_valid;
  logic [2*N_WAY-1:0]              rdata_type;
  logic [SYN_WIDTH*N_WAY-1:0]      rdata_syn;
  logic [TAG_SIZE*N_WAY-1:0]       rdata_tag;
  logic [CNT_WIDTH*N_WAY-1:0]      rdata_cnt;
  logic [DATA_WIDTH*N_WAY-1:0]     rdata_data;
  logic                            wren;
  logic                            winv;
  logic [IDX_SIZE-1:0]             waddr;
  logic [WAY_WIDTH-1:0]            wdata_line;
  logic [1:0]                      wdata_type;
  logic [SYN_WIDTH-1:0]            wdata_syn;
  logic [TAG_SIZE-1:0]             wdata_tag;
  logic [CNT_WIDTH-1:0]            wdata_cnt;
  logic [DATA_WIDTH-1:0]           wdata_data;
  logic                            inv_start;
  logic                            inv_busy;
  logic                            inv_done;

  modport slave (
    output req_ready,
    input  rden, raddr,
    output rdata_vld, rdata_valid, rdata_type, rdata_syn, rdata_tag, rdata_cnt, rdata_data,
    input  wren, winv, waddr, wdata_line, wdata_type, wdata_syn, wdata_tag, wdata_cnt, wdata_data,
    input  inv_start,
    output inv_busy, inv_done
  );

  modport master (
    input  req_ready,
    output rden, raddr,
    input  rdata_vld, rdata_valid, rdata_type, rdata_syn, rdata_tag, rdata_cnt, rdata_data,
    output wren, winv, waddr, wdata_line, wdata_type, wdata_syn, wdata_tag, wdata_cnt, wdata_data,
    output inv_start,
    input  inv_busy, inv_done
  );
endinterface

// File: rtl/drc_sram_bank.sv
// rtl/drc_sram_bank.sv - N_WAY set-associative line store with pipelined reads and invalidate-all sweep
// DRC_SRAM_WRFIRST_EN: collision returns the new write (write-first); undefined gives read-first.
module drc_sram_bank #(
  parameter int N_ENTRY    = 64,
  parameter int N_WAY      = 4,
  parameter int ADDR_SIZE  = 24,
  parameter int SYN_WIDTH  = 32,
  parameter int CNT_WIDTH  = 15,
  parameter int DATA_WIDTH = 272,
  parameter int RD_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  drc_sram_bank_if.slave bus
);
  localparam int N_SET     = N_ENTRY / N_WAY;
  localparam int IDX_SIZE  = $clog2(N_SET);
  localparam int TAG_SIZE  = ADDR_SIZE - IDX_SIZE;
  localparam int WAY_WIDTH = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  // Per-way packed layout, MSB first: {valid, type, syn, tag, cnt, data}
  localparam int OFS_CNT  = DATA_WIDTH;
  localparam int OFS_TAG  = OFS_CNT + CNT_WIDTH;
  localparam int OFS_SYN  = OFS_TAG + TAG_SIZE;
  localparam int OFS_TYPE = OFS_SYN + SYN_WIDTH;
  localparam int OFS_VAL  = OFS_TYPE + 2;
  localparam int WAY_BITS = OFS_VAL + 1;
  localparam int WORD_W   = N_WAY * WAY_BITS;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t              state;
  logic [IDX_SIZE-1:0] sweep_idx;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;

  logic                rd_acc;
  logic                wr_acc;

  logic [N_WAY-1:0]      valid_q  [N_SET];
  logic [1:0]            type_mem [N_WAY][N_SET];
  logic [SYN_WIDTH-1:0]  syn_mem  [N_WAY][N_SET];
  logic [TAG_SIZE-1:0]   tag_mem  [N_WAY][N_SET];
  logic [CNT_WIDTH-1:0]  cnt_mem  [N_WAY][N_SET];
  logic [DATA_WIDTH-1:0] data_mem [N_WAY][N_SET];

  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] pvld;

  assign rd_acc = bus.rden & ready_q;
  assign wr_acc = bus.wren & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sweep_idx <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.inv_start) begin
            state     <= S_SWEEP;
            sweep_idx <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (sweep_idx == IDX_SIZE'(N_SET - 1)) begin
            state   <= S_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.inv_busy  = busy_q;
  assign bus.inv_done  = done_q;

  // No request is accepted during SWEEP, so the sweep never races a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SET; s++) begin
        valid_q[s] <= '0;
      end
    end else if (state == S_SWEEP) begin
      valid_q[sweep_idx] <= '0;
    end else if (wr_acc) begin
      valid_q[bus.waddr][bus.wdata_line] <= ~bus.winv;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.winv) begin
      type_mem[bus.wdata_line][bus.waddr] <= bus.wdata_type;
      syn_mem[bus.wdata_line][bus.waddr]  <= bus.wdata_syn;
      tag_mem[bus.wdata_line][bus.waddr]  <= bus.wdata_tag;
      cnt_mem[bus.wdata_line][bus.waddr]  <= bus.wdata_cnt;
      data_mem[bus.wdata_line][bus.waddr] <= bus.wdata_data;
    end
  end

`ifdef DRC_SRAM_WRFIRST_EN
  logic collide;
  assign collide = rd_acc & wr_acc & (bus.raddr == bus.waddr);
`endif

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < N_WAY; w++) begin
      logic                  wv;
      logic [1:0]            wt;
      logic [SYN_WIDTH-1:0]  ws;
      logic [TAG_SIZE-1:0]   wg;
      logic [CNT_WIDTH-1:0]  wc;
      logic [DATA_WIDTH-1:0] wd;
      wv = valid_q[bus.raddr][w];
      wt = type_mem[w][bus.raddr];
      ws = syn_mem[w][bus.raddr];
      wg = tag_mem[w][bus.raddr];
      wc = cnt_mem[w][bus.raddr];
      wd = data_mem[w][bus.raddr];
`ifdef DRC_SRAM_WRFIRST_EN
      if (collide && (int'(bus.wdata_line) == w)) begin
        wv = ~bus.winv;
        if (!bus.winv) begin
          wt = bus.wdata_type;
          ws = bus.wdata_syn;
          wg = bus.wdata_tag;
          wc = bus.wdata_cnt;
          wd = bus.wdata_data;
        end
      end
`endif
      rd_word[w*WAY_BITS +: WAY_BITS] = {wv, wt, ws, wg, wc, wd};
    end
  end

  // Middle stages shift freely; the last stage is the output and only loads a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pvld[0] <= rd_acc;
      if ((RD_LATENCY > 1) || rd_acc) begin
        pipe[0] <= rd_word;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pvld[k] <= pvld[k-1];
        if ((k < RD_LATENCY - 1) || pvld[k-1]) begin
          pipe[k] <= pipe[k-1];
        end
      end
    end
  end

  assign bus.rdata_vld = pvld[RD_LATENCY-1];

  for (genvar w = 0; w < N_WAY; w++) begin : g_out
    localparam int B = w * WAY_BITS;
    assign bus.rdata_valid[w]                         = pipe[RD_LATENCY-1][B + OFS_VAL];
    assign bus.rdata_type[2*w +: 2]                   = pipe[RD_LATENCY-1][B + OFS_TYPE +: 2];
    assign bus.rdata_syn[SYN_WIDTH*w +: SYN_WIDTH]    = pipe[RD_LATENCY-1][B + OFS_SYN +: SYN_WIDTH];
    assign bus.rdata_tag[TAG_SIZE*w +: TAG_SIZE]      = pipe[RD_LATENCY-1][B + OFS_TAG +: TAG_SIZE];
    assign bus.rdata_cnt[CNT_WIDTH*w +: CNT_WIDTH]    = pipe[RD_LATENCY-1][B + OFS_CNT +: CNT_WIDTH];
    assign bus.rdata_data[DATA_WIDTH*w +: DATA_WIDTH] = pipe[RD_LATENCY-1][B +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_drc_sram_bank.sv
// tb/tb_drc_sram_bank.sv - bench for drc_sram_bank, latency 1 and 3 instances in lockstep
// Behavioural model: per-line arrays plus a queue of expected read results per instance.
module tb_drc_sram_bank;
  localparam int N_ENTRY = 64;
  localparam int N_WAY   = 4;
  localparam int ADDR_W  = 24;
  localparam int SYN_W   = 32;
  localparam int CNT_W   = 15;
  localparam int DATA_W  = 272;
  localparam int N_SET   = N_ENTRY / N_WAY;
  localparam int IDX_W   = $clog2(N_SET);
  localparam int TAG_W   = ADDR_W - IDX_W;
  localparam int WAY_W   = $clog2(N_WAY);

  typedef struct {
    int                       due;
    logic [N_WAY-1:0]         valid;
    logic [N_WAY-1:0]         known;
    logic [2*N_WAY-1:0]       typ;
    logic [SYN_W*N_WAY-1:0]   syn;
    logic [TAG_W*N_WAY-1:0]   tag;
    logic [CNT_W*N_WAY-1:0]   cnt;
    logic [DATA_W*N_WAY-1:0]  data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              rden, wren, winv, inv_start;
  logic [IDX_W-1:0]  raddr, waddr;
  logic [WAY_W-1:0]  wline;
  logic [1:0]        wtype;
  logic [SYN_W-1:0]  wsyn;
  logic [TAG_W-1:0]  wtag;
  logic [CNT_W-1:0]  wcnt;
  logic [DATA_W-1:0] wdata;

  drc_sram_bank_if #(.N_ENTRY(N_ENTRY), .N_WAY(N_WAY), .ADDR_SIZE(ADDR_W), .SYN_WIDTH(SYN_W),
                     .CNT_WIDTH(CNT_W), .DATA_WIDTH(DATA_W)) b1 ();
  drc_sram_bank_if #(.N_ENTRY(N_ENTRY), .N_WAY(N_WAY), .ADDR_SIZE(ADDR_W), .SYN_WIDTH(SYN_W),
                     .CNT_WIDTH(CNT_W), .DATA_WIDTH(DATA_W)) b3 ();

  drc_sram_bank #(.N_ENTRY(N_ENTRY), .N_WAY(N_WAY), .ADDR_SIZE(ADDR_W), .SYN_WIDTH(SYN_W),
                  .CNT_WIDTH(CNT_W), .DATA_WIDTH(DATA_W), .RD_LATENCY(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  drc_sram_bank #(.N_ENTRY(N_ENTRY), .N_WAY(N_WAY), .ADDR_SIZE(ADDR_W), .SYN_WIDTH(SYN_W),
                  .CNT_WIDTH(CNT_W), .DATA_WIDTH(DATA_W), .RD_LATENCY(3))
    u_lat3 (.clk(clk), .rst(rst), .bus(b3));

  assign b1.rden = rden;       assign b3.rden = rden;
  assign b1.raddr = raddr;     assign b3.raddr = raddr;
  assign b1.wren = wren;       assign b3.wren = wren;
  assign b1.winv = winv;       assign b3.winv = winv;
  assign b1.waddr = waddr;     assign b3.waddr = waddr;
  assign b1.wdata_line = wline; assign b3.wdata_line = wline;
  assign b1.wdata_type = wtype; assign b3.wdata_type = wtype;
  assign b1.wdata_syn = wsyn;   assign b3.wdata_syn = wsyn;
  assign b1.wdata_tag = wtag;   assign b3.wdata_tag = wtag;
  assign b1.wdata_cnt = wcnt;   assign b3.wdata_cnt = wcnt;
  assign b1.wdata_data = wdata; assign b3.wdata_data = wdata;
  assign b1.inv_start = inv_start; assign b3.inv_start = inv_start;

  logic                      rdy_o [2], busy_o [2], done_o [2], vld_o [2];
  logic [N_WAY-1:0]          val_o [2];
  logic [2*N_WAY-1:0]        typ_o [2];
  logic [SYN_W*N_WAY-1:0]    syn_o [2];
  logic [TAG_W*N_WAY-1:0]    tag_o [2];
  logic [CNT_W*N_WAY-1:0]    cnt_o [2];
  logic [DATA_W*N_WAY-1:0]   dat_o [2];

  assign rdy_o[0] = b1.req_ready;   assign rdy_o[1] = b3.req_ready;
  assign busy_o[0] = b1.inv_busy;   assign busy_o[1] = b3.inv_busy;
  assign done_o[0] = b1.inv_done;   assign done_o[1] = b3.inv_done;
  assign vld_o[0] = b1.rdata_vld;   assign vld_o[1] = b3.rdata_vld;
  assign val_o[0] = b1.rdata_valid; assign val_o[1] = b3.rdata_valid;
  assign typ_o[0] = b1.rdata_type;  assign typ_o[1] = b3.rdata_type;
  assign syn_o[0] = b1.rdata_syn;   assign syn_o[1] = b3.rdata_syn;
  assign tag_o[0] = b1.rdata_tag;   assign tag_o[1] = b3.rdata_tag;
  assign cnt_o[0] = b1.rdata_cnt;   assign cnt_o[1] = b3.rdata_cnt;
  assign dat_o[0] = b1.rdata_data;  assign dat_o[1] = b3.rdata_data;

  // Reference model state
  bit                m_valid [N_SET][N_WAY];
  bit                m_known [N_SET][N_WAY];
  logic [1:0]        m_type  [N_SET][N_WAY];
  logic [SYN_W-1:0]  m_syn   [N_SET][N_WAY];
  logic [TAG_W-1:0]  m_tag   [N_SET][N_WAY];
  logic [CNT_W-1:0]  m_cnt   [N_SET][N_WAY];
  logic [DATA_W-1:0] m_data  [N_SET][N_WAY];
  bit                m_ready, m_busy, m_done;
  int                sweep_set;
  rd_exp_t           q [2][$];
  rd_exp_t           last [2];
  int                lat [2] = '{1, 3};
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N_SET; s++)
      for (int w = 0; w < N_WAY; w++) begin
        m_valid[s][w] = 1'b0;
        m_known[s][w] = 1'b0;
      end
    m_ready = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b0;
    sweep_set = 0;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      last[d].due = 0;
      last[d].valid = '0;
      last[d].known = '1;
      last[d].typ = '0;
      last[d].syn = '0;
      last[d].tag = '0;
      last[d].cnt = '0;
      last[d].data = '0;
    end
  endtask

  task automatic model_edge();
    rd_exp_t e;
    bit ra, wa;
    int s, tw;
    ra = rden && m_ready;
    wa = wren && m_ready;
    s = int'(raddr);
    tw = int'(wline);
    if (ra) begin
      for (int w = 0; w < N_WAY; w++) begin
        e.valid[w] = m_valid[s][w];
        e.known[w] = m_known[s][w];
        e.typ[2*w +: 2] = m_type[s][w];
        e.syn[SYN_W*w +: SYN_W] = m_syn[s][w];
        e.tag[TAG_W*w +: TAG_W] = m_tag[s][w];
        e.cnt[CNT_W*w +: CNT_W] = m_cnt[s][w];
        e.data[DATA_W*w +: DATA_W] = m_data[s][w];
      end
`ifdef DRC_SRAM_WRFIRST_EN
      if (wa && (waddr == raddr)) begin
        e.valid[tw] = !winv;
        e.known[tw] = !winv;
        e.typ[2*tw +: 2] = wtype;
        e.syn[SYN_W*tw +: SYN_W] = wsyn;
        e.tag[TAG_W*tw +: TAG_W] = wtag;
        e.cnt[CNT_W*tw +: CNT_W] = wcnt;
        e.data[DATA_W*tw +: DATA_W] = wdata;
      end
`endif
      for (int d = 0; d < 2; d++) begin
        e.due = cyc + lat[d] - 1;
        q[d].push_back(e);
      end
    end
    if (wa) begin
      s = int'(waddr);
      m_valid[s][tw] = !winv;
      if (!winv) begin
        m_known[s][tw] = 1'b1;
        m_type[s][tw] = wtype;
        m_syn[s][tw] = wsyn;
        m_tag[s][tw] = wtag;
        m_cnt[s][tw] = wcnt;
        m_data[s][tw] = wdata;
      end
    end
    if (m_busy) begin
      for (int w = 0; w < N_WAY; w++) m_valid[sweep_set][w] = 1'b0;
      if (sweep_set == N_SET - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_ready = 1'b1;
      end else begin
        sweep_set++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (inv_start) begin
      m_busy = 1'b1;
      m_ready = 1'b0;
      sweep_set = 0;
    end
  endtask

  task automatic check_dut(input int d);
    bit expv;
    expv = 1'b0;
    if (q[d].size() != 0 && q[d][0].due == cyc) begin
      expv = 1'b1;
      last[d] = q[d].pop_front();
    end
    chk($sformatf("L%0d req_ready", lat[d]), rdy_o[d], m_ready);
    chk($sformatf("L%0d inv_busy", lat[d]), busy_o[d], m_busy);
    chk($sformatf("L%0d inv_done", lat[d]), done_o[d], m_done);
    chk($sformatf("L%0d rdata_vld c%0d", lat[d], cyc), vld_o[d], expv);
    chk($sformatf("L%0d rdata_valid c%0d", lat[d], cyc), val_o[d], last[d].valid);
    for (int w = 0; w < N_WAY; w++) begin
      if (last[d].known[w]) begin
        chk($sformatf("L%0d type w%0d c%0d", lat[d], w, cyc), typ_o[d][2*w +: 2], last[d].typ[2*w +: 2]);
        chk($sformatf("L%0d syn w%0d c%0d", lat[d], w, cyc), syn_o[d][SYN_W*w +: SYN_W], last[d].syn[SYN_W*w +: SYN_W]);
        chk($sformatf("L%0d tag w%0d c%0d", lat[d], w, cyc), tag_o[d][TAG_W*w +: TAG_W], last[d].tag[TAG_W*w +: TAG_W]);
        chk($sformatf("L%0d cnt w%0d c%0d", lat[d], w, cyc), cnt_o[d][CNT_W*w +: CNT_W], last[d].cnt[CNT_W*w +: CNT_W]);
        chk($sformatf("L%0d data w%0d c%0d", lat[d], w, cyc), dat_o[d][DATA_W*w +: DATA_W], last[d].data[DATA_W*w +: DATA_W]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic idle_inputs();
    rden = 1'b0; wren = 1'b0; winv = 1'b0; inv_start = 1'b0;
  endtask

  task automatic rand_payload();
    wtype = 2'($urandom);
    wsyn = $urandom;
    wtag = TAG_W'($urandom);
    wcnt = CNT_W'($urandom);
    wdata = '0;
    for (int i = 0; i < 9; i++) wdata = (wdata << 32) | DATA_W'($urandom);
  endtask

  task automatic write_line(input int s, input int w, input bit inv);
    wren = 1'b1; winv = inv; waddr = IDX_W'(s); wline = WAY_W'(w);
  endtask

  task automatic fill_all();
    for (int s = 0; s < N_SET; s++)
      for (int w = 0; w < N_WAY; w++) begin
        rand_payload();
        write_line(s, w, 1'b0);
        step();
      end
    idle_inputs();
  endtask

  task automatic read_all();
    for (int s = 0; s < N_SET; s++) begin
      rden = 1'b1; raddr = IDX_W'(s);
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  int busy_cnt, done_cnt;

  initial begin
    idle_inputs();
    raddr = '0; waddr = '0; wline = '0;
    rand_payload();
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // read set 0 straight after reset
    rden = 1'b1; raddr = '0;
    step();
    idle_inputs();
    repeat (4) step();

    // write set 5 way 2, then read it back next cycle
    rand_payload();
    wtag = TAG_W'(32'h1234); wcnt = CNT_W'(7); wtype = 2'd2;
    write_line(5, 2, 1'b0);
    step();
    idle_inputs();
    rden = 1'b1; raddr = IDX_W'(5);
    step();
    idle_inputs();
    repeat (4) step();

    // back-to-back reads 1,2,3; write to set 2 lands while set-2 result is in flight
    rden = 1'b1; raddr = IDX_W'(1); step();
    raddr = IDX_W'(2); step();
    raddr = IDX_W'(3); rand_payload(); write_line(2, 0, 1'b0); step();
    idle_inputs();
    repeat (5) step();

    // collision on set 9 way 1: store, overwrite, then invalidate
    rand_payload(); wtag = TAG_W'(32'h111);
    write_line(9, 1, 1'b0); step();
    idle_inputs();
    rand_payload(); wtag = TAG_W'(32'hABC);
    rden = 1'b1; raddr = IDX_W'(9); write_line(9, 1, 1'b0); step();
    idle_inputs();
    repeat (4) step();
    rden = 1'b1; raddr = IDX_W'(9); write_line(9, 1, 1'b1); step();
    idle_inputs();
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      rden = 1'($urandom);
      raddr = IDX_W'($urandom);
      wren = 1'($urandom);
      winv = ($urandom_range(0, 3) == 0);
      waddr = ($urandom_range(0, 3) == 0) ? raddr : IDX_W'($urandom);
      wline = WAY_W'($urandom);
      inv_start = ($urandom_range(0, 40) == 0);
      step();
    end
    idle_inputs();
    repeat (20) step();

    // invalidate-all sweep with a request in the start cycle and dropped traffic during it
    fill_all();
    rden = 1'b1; raddr = IDX_W'(3); rand_payload(); write_line(4, 0, 1'b0);
    inv_start = 1'b1;
    step();
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < N_SET + 2; i++) begin
      rand_payload();
      rden = (i < N_SET) ? 1'($urandom) : 1'b0;
      raddr = IDX_W'($urandom);
      wren = (i < N_SET) ? 1'($urandom) : 1'b0;
      winv = 1'b0;
      waddr = IDX_W'($urandom);
      wline = WAY_W'($urandom);
      inv_start = (i < N_SET) ? 1'($urandom) : 1'b0;
      step();
      busy_cnt += int'(b1.inv_busy);
      done_cnt += int'(b1.inv_done);
    end
    chk("sweep busy cycles", DATA_W'(busy_cnt), DATA_W'(N_SET - 1));
    chk("sweep done pulses", DATA_W'(done_cnt), DATA_W'(1));
    idle_inputs();
    read_all();

    // reset in the middle of a sweep
    fill_all();
    inv_start = 1'b1;
    step();
    idle_inputs();
    repeat (7) step();
    rst = 1'b1;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
